entropy_reader: RTL
===================

Name: entropy_reader

Overview:
- Bus initiator that drives the entropy core's register interface (cs/we/addr/dwrite/dread).
- After reset it programs the ring-oscillator control bytes rng1/rng2, then periodically reads the P and N oscillator banks.
- XOR-whitens each P/N pair into 16 bits and packs two samples into a 32-bit word, offered on a valid/ready stream.
- Runs a repetition health check and raises a sticky error if the whitened value gets stuck.

Parameters:
- RNG1_INIT, 8'h55, value written to rng1 at init.
- RNG2_INIT, 8'haa, value written to rng2 at init; must be the bitwise inverse of RNG1_INIT.
- SAMPLE_WAIT, 16'd64, WAIT cycles before each sample pair; legal range 1..65535.
- REPEAT_MAX, 8'd4, consecutive identical whitened samples that set health_err; legal range >=1.
- ADDR_WR_RNG1, 8'h00; ADDR_WR_RNG2, 8'h01; ADDR_RD_P, 8'h11; ADDR_RD_N, 8'h12: target register addresses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits new sampling; checked only in WAIT
- cs  out  1  chip select to entropy core
- we  out  1  write enable to entropy core
- addr  out  8  register address
- dwrite  out  16  write data
- dread  in  16  read data; combinational from the target, valid in the same cycle as cs&~we
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- out_data  out  32  packed whitened word
- health_err  out  1  sticky repetition failure
- debug  out  8  {health_err, 4'b0, state[2:0]}

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; it is sampled only on the posedge of clk.
- Bus outputs are a combinational decode of the state register. Outside the states listed below: cs=0, we=0, addr=8'h00, dwrite=16'h0000.
- Reset values:
  - state=INIT_RNG1; wait_ctr=0; half=0; acc=0; p_reg=0; last_mix=0; rep_ctr=0.
  - out_valid=0; out_data=0; health_err=0.
- States:
  - INIT_RNG1: cs=1, we=1, addr=ADDR_WR_RNG1, dwrite={RNG1_INIT,8'h00}. Goes to INIT_RNG2 after one cycle.
  - INIT_RNG2: cs=1, we=1, addr=ADDR_WR_RNG2, dwrite={8'h00,RNG2_INIT}. Goes to WAIT after one cycle; wait_ctr is loaded with SAMPLE_WAIT-1.
  - WAIT:
    - If wait_ctr!=0, decrement every cycle regardless of enable.
    - If wait_ctr==0 and enable=1, go to READ_P.
    - If wait_ctr==0 and enable=0, hold in WAIT.
  - READ_P: cs=1, we=0, addr=ADDR_RD_P. p_reg<=dread at the exiting edge. Goes to READ_N.
  - READ_N: cs=1, we=0, addr=ADDR_RD_N. At the exiting edge, mix=p_reg^dread and acc<={acc[15:0],mix}; the first sample of a word ends up in [31:16].
    - Health check: if mix==last_mix, rep_ctr<=rep_ctr+1 (saturating at 8'hff); otherwise rep_ctr<=0. Then last_mix<=mix.
    - health_err is set when the incremented rep_ctr equals REPEAT_MAX. It is cleared only by reset.
    - Because last_mix resets to 0, a first mix of 16'h0000 counts as a repeat.
    - If half==0: half<=1, go to WAIT, reload wait_ctr.
    - If half==1: half<=0, go to OUTPUT; out_data<=new acc and out_valid<=1 at that same edge.
- OUTPUT:
  - Hold out_valid=1 with out_data stable until out_ready=1.
  - On the ready edge: out_valid<=0, go to WAIT, reload wait_ctr.
  - No bus activity in OUTPUT; backpressure stalls sampling indefinitely.
- enable=0 never aborts a pair or word in progress. It only stalls at WAIT expiry.
- health_err does not stop sampling or output; it is a flag only.
- Reset mid-operation: all state returns to reset values next edge; any pending word is dropped; init writes repeat.
- Latency: with SAMPLE_WAIT=W, the first out_valid appears at cycle 2+2*(W+2) counted from the first cycle after reset deassertion (cycle 0 = INIT_RNG1), provided enable=1 throughout. Steady-state word period is 2*(W+2)+1 cycles with out_ready=1.

Test Plan:
- Reset release, W=4, enable=1: cycle0 write addr 00 dwrite 5500; cycle1 write addr 01 dwrite 00aa; cs low cycles 2-5; cycle6 read 11; cycle7 read 12.
- Target returns P=16'h1234, N=16'h00ff then P=16'hf0f0, N=16'h0f0f -> out_valid at cycle 14, out_data=32'h12cbffff; held while out_ready=0 for 10 cycles, clears the cycle after out_ready=1.
- enable=0 before the first WAIT expires -> no read cycles; set enable=1 -> READ_P next cycle. Drop enable during READ_N -> word still completes.
- REPEAT_MAX=4, P=N constant (mix=0) -> health_err rises at the edge ending the 4th READ_N, stays high, and words keep flowing with data 0.
- Alternating mix values 16'h0001/16'h0002 for 20 samples -> health_err stays 0.
- Assert reset for 1 cycle during OUTPUT -> out_valid=0 next cycle, bus restarts with the INIT_RNG1 write, health_err cleared.

Source files
------------

// File: rtl/entropy_reader.sv
// Bus initiator for the entropy core: programs the ring-oscillator controls, then samples
// the P/N banks, XOR-whitens each pair and streams packed 32-bit words with a repetition check.
module entropy_reader #(
  parameter logic [7:0]  RNG1_INIT    = 8'h55,
  parameter logic [7:0]  RNG2_INIT    = 8'haa,
  parameter logic [15:0] SAMPLE_WAIT  = 16'd64,
  parameter logic [7:0]  REPEAT_MAX   = 8'd4,
  parameter logic [7:0]  ADDR_WR_RNG1 = 8'h00,
  parameter logic [7:0]  ADDR_WR_RNG2 = 8'h01,
  parameter logic [7:0]  ADDR_RD_P    = 8'h11,
  parameter logic [7:0]  ADDR_RD_N    = 8'h12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        cs,
  output logic        we,
  output logic [7:0]  addr,
  output logic [15:0] dwrite,
  input  logic [15:0] dread,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        health_err,
  output logic [7:0]  debug
);

  typedef enum logic [2:0] {
    S_INIT_RNG1 = 3'd0,
    S_INIT_RNG2 = 3'd1,
    S_WAIT      = 3'd2,
    S_READ_P    = 3'd3,
    S_READ_N    = 3'd4,
    S_OUTPUT    = 3'd5
  } state_t;

  localparam logic [15:0] WAIT_RELOAD = SAMPLE_WAIT - 16'd1;

  state_t      state_reg, state_next;
  logic [15:0] wait_ctr_reg, wait_ctr_next;
  logic        half_reg, half_next;
  logic [31:0] acc_reg, acc_next;
  logic [15:0] p_reg, p_next;
  logic [15:0] last_mix_reg, last_mix_next;
  logic [7:0]  rep_ctr_reg, rep_ctr_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_data_reg, out_data_next;
  logic        health_err_reg, health_err_next;

  logic [15:0] mix;
  logic [7:0]  rep_inc;

  assign mix     = p_reg ^ dread;
  assign rep_inc = (rep_ctr_reg == 8'hff) ? 8'hff : rep_ctr_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_INIT_RNG1;
      wait_ctr_reg   <= 16'h0000;
      half_reg       <= 1'b0;
      acc_reg        <= 32'h0000_0000;
      p_reg          <= 16'h0000;
      last_mix_reg   <= 16'h0000;
      rep_ctr_reg    <= 8'h00;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= 32'h0000_0000;
      health_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_ctr_reg   <= wait_ctr_next;
      half_reg       <= half_next;
      acc_reg        <= acc_next;
      p_reg          <= p_next;
      last_mix_reg   <= last_mix_next;
      rep_ctr_reg    <= rep_ctr_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      health_err_reg <= health_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wait_ctr_next   = wait_ctr_reg;
    half_next       = half_reg;
    acc_next        = acc_reg;
    p_next          = p_reg;
    last_mix_next   = last_mix_reg;
    rep_ctr_next    = rep_ctr_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    health_err_next = health_err_reg;
    case (state_reg)
      S_INIT_RNG1: state_next = S_INIT_RNG2;
      S_INIT_RNG2: begin
        state_next    = S_WAIT;
        wait_ctr_next = WAIT_RELOAD;
      end
      S_WAIT: begin
        // The countdown runs regardless of enable; enable only gates leaving WAIT.
        if (wait_ctr_reg != 16'h0000) begin
          wait_ctr_next = wait_ctr_reg - 16'd1;
        end else if (enable) begin
          state_next = S_READ_P;
        end
      end
      S_READ_P: begin
        p_next     = dread;
        state_next = S_READ_N;
      end
      S_READ_N: begin
        acc_next      = {acc_reg[15:0], mix};
        last_mix_next = mix;
        if (mix == last_mix_reg) begin
          rep_ctr_next = rep_inc;
          if (rep_inc == REPEAT_MAX) begin
            health_err_next = 1'b1;
          end
        end else begin
          rep_ctr_next = 8'h00;
        end
        if (!half_reg) begin
          half_next     = 1'b1;
          state_next    = S_WAIT;
          wait_ctr_next = WAIT_RELOAD;
        end else begin
          half_next      = 1'b0;
          state_next     = S_OUTPUT;
          out_data_next  = {acc_reg[15:0], mix};
          out_valid_next = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_WAIT;
          wait_ctr_next  = WAIT_RELOAD;
        end
      end
      default: state_next = S_INIT_RNG1;
    endcase
  end

  // Bus signals are a pure decode of the current state.
  always_comb begin
    cs     = 1'b0;
    we     = 1'b0;
    addr   = 8'h00;
    dwrite = 16'h0000;
    case (state_reg)
      S_INIT_RNG1: begin
        cs     = 1'b1;
        we     = 1'b1;
        addr   = ADDR_WR_RNG1;
        dwrite = {RNG1_INIT, 8'h00};
      end
      S_INIT_RNG2: begin
        cs     = 1'b1;
        we     = 1'b1;
        addr   = ADDR_WR_RNG2;
        dwrite = {8'h00, RNG2_INIT};
      end
      S_READ_P: begin
        cs   = 1'b1;
        addr = ADDR_RD_P;
      end
      S_READ_N: begin
        cs   = 1'b1;
        addr = ADDR_RD_N;
      end
      default: begin
        cs     = 1'b0;
        we     = 1'b0;
        addr   = 8'h00;
        dwrite = 16'h0000;
      end
    endcase
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign health_err = health_err_reg;
  assign debug      = {health_err_reg, 4'b0000, state_reg};

endmodule
